modn_updown_counter: RTL and testbench
======================================

// Module: modn_updown_counter
// PURPOSE
//  Programmable modulo-N counter, up or down, generalising the fixed mod-9 up counter.
//  - Down mode is the reverse direction of the existing counter.
//  - Modulus is reloaded at runtime through a valid/ready handshake.
//  - Raises a one-cycle terminal-count pulse on each wrap.
//  - Produces a divided square wave for downstream timing logic.
// PARAMETERS
//  WIDTH        4   count/modulus width in bits
//  MOD_DEFAULT  9   modulus after reset; legal range 2..2**WIDTH-1
// PORTS
//  clk        in   1      single clock; all logic on posedge clk
//  reset      in   1      synchronous, active-high; dominates every other input
//  en         in   1      count enable; 0 = hold all state except the handshake
//  up_dn      in   1      1 = count up, 0 = count down; sampled every edge
//  mod_valid  in   1      a new modulus is offered on mod_in
//  mod_in     in   WIDTH  requested modulus
//  mod_ready  out  1      new modulus can be accepted
//  mod_active out  WIDTH  modulus currently in force
//  count      out  WIDTH  current count value
//  tc         out  1      one-cycle pulse, high in the cycle after a wrap edge
//  div_out    out  1      toggles on every wrap edge
// BEHAVIOUR
//  Reset values: count=0, tc=0, div_out=0, mod_active=MOD_DEFAULT, mod_ready=1, pending cleared.
//  Counting (en=1), with M = mod_active:
//  - up:   count+1; at count==M-1 the next edge wraps to 0.
//  - down: count-1; at count==0 the next edge wraps to M'-1.
//  - M' is the modulus in force after that same edge (it may be a pending value applied at this wrap).
//  - count is always < mod_active; the counter never leaves the legal range.
//  Direction change mid-count: no jump; the next edge steps from the current value in the new direction.
//  en=0: count, tc(=0) and div_out hold; no wrap occurs.
//  tc / div_out: a wrap edge registers tc=1 for exactly one cycle and toggles div_out.
//  - With en held high, tc period = M cycles and div_out period = 2M cycles.
//  Modulus handshake:
//  - Transfer occurs on an edge where mod_valid & mod_ready are both high.
//  - Value is clamped: mod_in<2 becomes 2. It is stored as pending, and mod_ready=0 from the next cycle.
//  - The pending value is applied at the next wrap edge: mod_active updates, mod_ready returns to 1.
//  - A transfer on the same edge as a wrap is not applied at that wrap; it waits for the following wrap.
//  - While en=0 the pending value stays pending indefinitely.
//  - mod_valid while mod_ready=0 is ignored. The offering side must hold the value until it sees ready.
//  Reset mid-operation: pending value discarded; all outputs return to their reset values on that edge.
//  Width rule: all arithmetic is modulo 2**WIDTH internally, but the wrap logic prevents overflow.
// STRUCTURE
//  Package modn_pkg:
//  - WIDTH_DEF, MOD_DEFAULT_DEF constants
//  - function clamp_mod(in) returning max(in,2)
//  Sub-module modn_mod_holder:
//  - owns the handshake, pending register, mod_ready and mod_active
//  - input apply_wrap from the counter core
//  Top level keeps the count register, direction/wrap decode, tc and div_out registers.
// TESTING
//  1 reset; en=1, up_dn=1 -> count 0..8,0,...; tc high when count returns to 0, every 9 cycles;
//    div_out period 18.
//  2 reset; en=1, up_dn=0 -> count 0,8,7,...,1,0,8; tc high in each cycle where count=8 after wrap.
//  3 up mode, handshake mod_in=5 at count=3 -> mod_ready=0; count runs 4..8, wraps to 0;
//    mod_active=5, mod_ready=1; then 0..4,0.
//  4 mod_in=1 accepted -> after next wrap mod_active=2; count 0,1,0,1; tc every 2 cycles.
//  5 pending modulus 5, reset at count=6 -> next cycle count=0, mod_active=9, mod_ready=1,
//    tc=0, div_out=0; the value 5 is never applied.
//  6 en=0 at count=4 for 3 cycles -> count holds 4, tc=0;
//    then en=1 with up_dn=0 -> count 3,2,1,0,8.

Source files
------------

// File: rtl/modn_pkg.sv
// Shared constants and helpers for the programmable modulo-N up/down counter.
package modn_pkg;

  localparam int WIDTH_DEF       = 4;
  localparam int MOD_DEFAULT_DEF = 9;

  // A modulus below 2 cannot produce a wrap, so it is raised to the smallest legal value.
  function automatic int unsigned clamp_mod(input int unsigned mod_req);
    return (mod_req < 2) ? 2 : mod_req;
  endfunction

endpackage

// File: rtl/modn_updown_counter_if.sv
// Valid/ready channel that carries a new modulus into the counter.
interface modn_updown_counter_if
  import modn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             mod_valid;
  logic [WIDTH-1:0] mod_in;
  logic             mod_ready;

  modport master (output mod_valid, output mod_in, input  mod_ready);
  modport slave  (input  mod_valid, input  mod_in, output mod_ready);

endinterface

// File: rtl/modn_mod_holder.sv
// Owns the modulus handshake: one pending slot, applied to the active modulus on the next wrap.
module modn_mod_holder
  import modn_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int MOD_DEFAULT = MOD_DEFAULT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  apply_wrap,
  modn_updown_counter_if.slave  mod_if,
  output logic [WIDTH-1:0]      mod_active,
  output logic [WIDTH-1:0]      mod_next
);

  logic [WIDTH-1:0] mod_active_q, mod_active_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             pending_vld_q, pending_vld_d;
  logic             accept;

  assign accept = mod_if.mod_valid && !pending_vld_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    mod_active_d  = mod_active_q;
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    // Apply and accept are exclusive: accepting needs an empty slot, applying needs a full one.
    if (apply_wrap && pending_vld_q) begin
      mod_active_d  = pending_q;
      pending_vld_d = 1'b0;
    end else if (accept) begin
      pending_d     = WIDTH'(clamp_mod(32'(mod_if.mod_in)));
      pending_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      mod_active_q  <= WIDTH'(MOD_DEFAULT);
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
    end else begin
      mod_active_q  <= mod_active_d;
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
    end
  end

  assign mod_if.mod_ready = !pending_vld_q;
  assign mod_active       = mod_active_q;
  assign mod_next         = mod_active_d;

endmodule

// File: rtl/modn_updown_counter.sv
// Programmable modulo-N up/down counter with terminal-count pulse and divided square wave.
module modn_updown_counter
  import modn_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int MOD_DEFAULT = MOD_DEFAULT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  modn_updown_counter_if.slave  mod_if,
  output logic [WIDTH-1:0]      mod_active,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  div_out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] mod_next;
  logic             wrap;

  // Up wraps from M-1, down wraps from 0; nothing wraps while disabled.
  assign wrap = en && (up_dn ? (count_q == mod_active - ONE) : (count_q == '0));

  modn_mod_holder #(
    .WIDTH       (WIDTH),
    .MOD_DEFAULT (MOD_DEFAULT)
  ) u_mod_holder (
    .clk        (clk),
    .reset      (reset),
    .apply_wrap (wrap),
    .mod_if     (mod_if),
    .mod_active (mod_active),
    .mod_next   (mod_next)
  );

  always_comb begin
    count_d = count_q;
    if (wrap) begin
      // A down wrap lands on the top of the modulus in force after this edge.
      count_d = up_dn ? '0 : mod_next - ONE;
    end else if (en) begin
      count_d = up_dn ? count_q + ONE : count_q - ONE;
    end
    tc_d  = wrap;
    div_d = div_q ^ wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      div_q   <= div_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign div_out = div_q;

endmodule

// File: tb/tb_modn_updown_counter.sv
// Directed bench for modn_updown_counter: hand-computed expectations checked after each edge.
module tb_modn_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic [3:0] mod_active;
  logic [3:0] count;
  logic       tc;
  logic       div_out;

  int checks   = 0;
  int failures = 0;

  modn_updown_counter_if #(.WIDTH(4)) mod_if ();

  modn_updown_counter #(
    .WIDTH       (4),
    .MOD_DEFAULT (9)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up_dn      (up_dn),
    .mod_if     (mod_if),
    .mod_active (mod_active),
    .count      (count),
    .tc         (tc),
    .div_out    (div_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge; inputs are also changed there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input int exp_cnt, input int exp_tc);
    tick();
    check({tag, ".count"}, 32'(count), 32'(exp_cnt));
    check({tag, ".tc"}, 32'(tc), 32'(exp_tc));
  endtask

  task automatic check_mod(input string tag, input int exp_act, input int exp_rdy);
    check({tag, ".mod_active"}, 32'(mod_active), 32'(exp_act));
    check({tag, ".mod_ready"}, 32'(mod_if.mod_ready), 32'(exp_rdy));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".count"}, 32'(count), 0);
    check({tag, ".tc"}, 32'(tc), 0);
    check({tag, ".div_out"}, 32'(div_out), 0);
    check_mod(tag, 9, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    en               = 1'b0;
    up_dn            = 1'b1;
    mod_if.mod_valid = 1'b0;
    mod_if.mod_in    = '0;
    tick();
    tick();
    check_reset_state("rst");
    reset = 1'b0;

    // 1: up count mod 9, tc each 9 cycles, div_out period 18.
    en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step("up9", i % 9, (i % 9 == 0) ? 1 : 0);
      check("up9.div_out", 32'(div_out), 32'((i / 9) % 2));
    end

    // 2: down count from reset: 8,7,...,0,8.
    do_reset();
    check_reset_state("rst2");
    up_dn = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step("dn9", (9 - i % 9) % 9, (i % 9 == 1) ? 1 : 0);
      check("dn9.div_out", 32'(div_out), 32'(((i + 8) / 9) % 2));
    end

    // 3: load modulus 5 at count 3; a second offer while not ready is ignored.
    do_reset();
    up_dn = 1'b1;
    step("h5.pre", 1, 0);
    step("h5.pre", 2, 0);
    step("h5.pre", 3, 0);
    mod_if.mod_valid = 1'b1;
    mod_if.mod_in    = 4'd5;
    step("h5.xfer", 4, 0);
    check_mod("h5.xfer", 9, 0);
    mod_if.mod_in = 4'd7;
    step("h5.ign", 5, 0);
    check_mod("h5.ign", 9, 0);
    mod_if.mod_valid = 1'b0;
    step("h5.run", 6, 0);
    step("h5.run", 7, 0);
    step("h5.run", 8, 0);
    step("h5.wrap", 0, 1);
    check_mod("h5.wrap", 5, 1);
    check("h5.wrap.div_out", 32'(div_out), 1);
    for (int i = 1; i <= 4; i++) step("m5", i, 0);
    step("m5.wrap", 0, 1);
    check("m5.wrap.div_out", 32'(div_out), 0);

    // 4: mod_in=1 clamps to 2.
    mod_if.mod_valid = 1'b1;
    mod_if.mod_in    = 4'd1;
    step("h1.xfer", 1, 0);
    check_mod("h1.xfer", 5, 0);
    mod_if.mod_valid = 1'b0;
    step("h1.run", 2, 0);
    step("h1.run", 3, 0);
    step("h1.run", 4, 0);
    step("h1.wrap", 0, 1);
    check_mod("h1.wrap", 2, 1);
    step("m2", 1, 0);
    step("m2", 0, 1);
    step("m2", 1, 0);
    step("m2", 0, 1);

    // 5: reset with a pending modulus discards it.
    do_reset();
    check_reset_state("rst5");
    mod_if.mod_valid = 1'b1;
    mod_if.mod_in    = 4'd5;
    step("r5.xfer", 1, 0);
    check_mod("r5.xfer", 9, 0);
    mod_if.mod_valid = 1'b0;
    for (int i = 2; i <= 6; i++) step("r5.run", i, 0);
    reset = 1'b1;
    tick();
    check_reset_state("r5.rst");
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) step("r5.after", i, 0);
    step("r5.wrap", 0, 1);
    check_mod("r5.wrap", 9, 1);

    // 6: hold with en=0, then count down across the wrap.
    for (int i = 1; i <= 4; i++) step("h.pre", i, 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) step("hold", 4, 0);
    en    = 1'b1;
    up_dn = 1'b0;
    step("hold.dn", 3, 0);
    step("hold.dn", 2, 0);
    step("hold.dn", 1, 0);
    step("hold.dn", 0, 0);
    step("hold.dn.wrap", 8, 1);

    // 7: transfer on the wrap edge waits for the following wrap.
    up_dn            = 1'b1;
    mod_if.mod_valid = 1'b1;
    mod_if.mod_in    = 4'd4;
    step("sw.xfer", 0, 1);
    check_mod("sw.xfer", 9, 0);
    mod_if.mod_valid = 1'b0;
    for (int i = 1; i <= 8; i++) step("sw.run", i, 0);
    step("sw.wrap", 0, 1);
    check_mod("sw.wrap", 4, 1);
    step("m4", 1, 0);
    step("m4", 2, 0);
    step("m4", 3, 0);
    step("m4", 0, 1);

    // 8: down wrap lands on new modulus minus one when the pending value applies there.
    up_dn            = 1'b0;
    mod_if.mod_valid = 1'b1;
    mod_if.mod_in    = 4'd6;
    step("dw.xfer", 3, 1);
    check_mod("dw.xfer", 4, 0);
    mod_if.mod_valid = 1'b0;
    step("dw.run", 2, 0);
    step("dw.run", 1, 0);
    step("dw.run", 0, 0);
    step("dw.wrap", 5, 1);
    check_mod("dw.wrap", 6, 1);
    step("dw.after", 4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
